// File: rtl/robot_motion_sequencer.sv
// Step sequencer pacing the left-wall navigation FSM: settle, sample, decide, move/turn.
// Optional spin detection is enabled by defining ROBOT_SEQ_LOOP_DETECT_EN.
module robot_motion_sequencer #(
  parameter int MOVE_CYCLES   = 8,
  parameter int TURN_CYCLES   = 12,
  parameter int SETTLE_CYCLES = 2,
  parameter int STEP_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              front_sensor,
  input  logic              left_sensor,
  input  logic              nav_front,
  input  logic              nav_turn,
  output logic              nav_step,
  output logic              sens_front,
  output logic              sens_left,
  output logic              motor_fwd,
  output logic              motor_turn,
  output logic              busy,
  output logic              step_done,
  output logic [STEP_W-1:0] step_count,
  output logic              fault,
  output logic              loop_flag
);

  localparam int TMAX0 = (MOVE_CYCLES > TURN_CYCLES) ? MOVE_CYCLES : TURN_CYCLES;
  localparam int TMAX  = (TMAX0 > SETTLE_CYCLES) ? TMAX0 : SETTLE_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_MOVE   = 3'd4;
  localparam logic [2:0] S_TURN   = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              stop_q, stop_d;
  logic              sf_q, sf_d;
  logic              sl_q, sl_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic              last;
  logic              loop_hit;
`ifdef ROBOT_SEQ_LOOP_DETECT_EN
  logic [2:0]        turn_q, turn_d;
  logic              loop_q, loop_d;
`endif

  assign last = (timer_q == TW'(1));

  // Next-state, timer, latches and counters
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stop_d   = stop_q;
    sf_d     = sf_q;
    sl_d     = sl_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    loop_hit = 1'b0;
`ifdef ROBOT_SEQ_LOOP_DETECT_EN
    turn_d   = turn_q;
    loop_d   = loop_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (start && !stop) begin
          state_d = S_SETTLE;
          timer_d = TW'(SETTLE_CYCLES);
        end
      end
      S_SETTLE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (last) begin
          sf_d    = front_sensor;
          sl_d    = left_sensor;
          state_d = S_SAMPLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_SAMPLE: begin
        stop_d  = stop_q | stop;
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        stop_d = stop_q | stop;
        if (nav_front && !nav_turn) begin
          state_d = S_MOVE;
          timer_d = TW'(MOVE_CYCLES);
        end else if (nav_turn && !nav_front) begin
          state_d = S_TURN;
          timer_d = TW'(TURN_CYCLES);
        end else begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end
      end
      S_MOVE, S_TURN: begin
        stop_d = stop_q | stop;
        if (!last) begin
          timer_d = timer_q - TW'(1);
        end else begin
          if (state_q == S_MOVE && cnt_q != '1) begin
            cnt_d = cnt_q + STEP_W'(1);
          end
`ifdef ROBOT_SEQ_LOOP_DETECT_EN
          if (state_q == S_TURN) begin
            turn_d   = turn_q + 3'd1;
            loop_hit = (turn_q == 3'd3);
          end else begin
            turn_d = 3'd0;
          end
          if (loop_hit) loop_d = 1'b1;
`endif
          if (loop_hit) begin
            state_d = S_HALT;
          end else if (stop_q || stop) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = S_SETTLE;
            timer_d = TW'(SETTLE_CYCLES);
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      stop_q  <= 1'b0;
      sf_q    <= 1'b0;
      sl_q    <= 1'b0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
`ifdef ROBOT_SEQ_LOOP_DETECT_EN
      turn_q  <= 3'd0;
      loop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stop_q  <= stop_d;
      sf_q    <= sf_d;
      sl_q    <= sl_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
`ifdef ROBOT_SEQ_LOOP_DETECT_EN
      turn_q  <= turn_d;
      loop_q  <= loop_d;
`endif
    end
  end

  assign nav_step   = (state_q == S_SAMPLE);
  assign motor_fwd  = (state_q == S_MOVE);
  assign motor_turn = (state_q == S_TURN);
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign step_done  = (state_q == S_MOVE || state_q == S_TURN) && last;
  assign sens_front = sf_q;
  assign sens_left  = sl_q;
  assign step_count = cnt_q;
  assign fault      = fault_q;
`ifdef ROBOT_SEQ_LOOP_DETECT_EN
  assign loop_flag  = loop_q;
`else
  assign loop_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_robot_motion_sequencer.sv
// Randomized bench for robot_motion_sequencer against a step-level timeline model.
// Works with or without ROBOT_SEQ_LOOP_DETECT_EN defined.
module tb_robot_motion_sequencer;

  localparam int MC = 8;
  localparam int TC = 12;
  localparam int SC = 2;
  localparam int SW = 3;
  localparam int CMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic reset, start, stop;
  logic front_sensor, left_sensor, nav_front, nav_turn;
  logic nav_step, sens_front, sens_left, motor_fwd, motor_turn;
  logic busy, step_done, fault, loop_flag;
  logic [SW-1:0] step_count;

  int checks = 0;
  int errors = 0;
  int m_cnt, m_turns;
  bit m_fault, m_loop, m_sf, m_sl;
  int o;

  robot_motion_sequencer #(
    .MOVE_CYCLES(MC), .TURN_CYCLES(TC),
    .SETTLE_CYCLES(SC), .STEP_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .front_sensor(front_sensor), .left_sensor(left_sensor),
    .nav_front(nav_front), .nav_turn(nav_turn),
    .nav_step(nav_step), .sens_front(sens_front),
    .sens_left(sens_left), .motor_fwd(motor_fwd),
    .motor_turn(motor_turn), .busy(busy),
    .step_done(step_done), .step_count(step_count),
    .fault(fault), .loop_flag(loop_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_turns = 0;
    m_fault = 0; m_loop = 0;
    m_sf = 0; m_sl = 0;
  endtask

  task automatic check_outs(input string t, input bit ns, input bit mf,
                            input bit mt, input bit bz, input bit sd);
    chk({t, ".nav_step"}, nav_step, ns);
    chk({t, ".motor_fwd"}, motor_fwd, mf);
    chk({t, ".motor_turn"}, motor_turn, mt);
    chk({t, ".busy"}, busy, bz);
    chk({t, ".step_done"}, step_done, sd);
    chk({t, ".step_count"}, step_count, m_cnt);
    chk({t, ".fault"}, fault, m_fault);
    chk({t, ".loop_flag"}, loop_flag, m_loop);
    chk({t, ".sens_front"}, sens_front, m_sf);
    chk({t, ".sens_left"}, sens_left, m_sl);
  endtask

  task automatic check_quiet(input string t);
    check_outs(t, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      check_quiet("idle");
      start = 0; stop = 0;
      front_sensor = 1'($urandom); left_sensor = 1'($urandom);
      tick();
    end
  endtask

  task automatic halt_hold(input int n);
    for (int k = 0; k < n; k++) begin
      check_quiet("halt_hold");
      start = 1; stop = 1'($urandom);
      tick();
    end
    start = 0; stop = 0;
  endtask

  task automatic do_reset();
    reset = 1; start = 1'($urandom);
    tick();
    reset = 0; start = 0;
    model_reset();
    check_quiet("reset");
  endtask

  task automatic do_start();
    start = 1; stop = 0;
    tick();
    start = 0;
  endtask

  // Runs one step starting in the first settle cycle.
  // kind: 0 move, 1 turn, 2 illegal decision. outcome: 0 next step, 1 idle, 2 halt.
  task automatic run_step(input int kind, input int stop_at,
                          input int rst_at, output int outcome);
    int n;
    int p;
    bit b;
    n = (kind == 1) ? TC : MC;
    p = SC + 2 + n;
    outcome = 0;
    for (int i = 0; i < p; i++) begin
      check_outs($sformatf("k%0d.c%0d", kind, i), i == SC,
                 kind == 0 && i >= SC + 2, kind == 1 && i >= SC + 2,
                 1, i == p - 1);
      front_sensor = 1'($urandom); left_sensor = 1'($urandom);
      nav_front = 1'($urandom); nav_turn = 1'($urandom);
      if (i == SC + 1) begin
        b = 1'($urandom);
        nav_front = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : b;
        nav_turn  = (kind == 1) ? 1'b1 : (kind == 0) ? 1'b0 : b;
      end
      stop = (i == stop_at);
      reset = (i == rst_at);
      if (reset) begin
        tick();
        reset = 0; stop = 0;
        model_reset();
        check_quiet("mid_reset");
        outcome = 1;
        return;
      end
      if (stop && i < SC) begin
        tick();
        stop = 0;
        check_quiet("settle_stop");
        outcome = 1;
        return;
      end
      if (i == SC - 1) begin
        m_sf = front_sensor; m_sl = left_sensor;
      end
      if (kind == 2 && i == SC + 1) begin
        tick();
        m_fault = 1;
        check_quiet("illegal");
        outcome = 2;
        return;
      end
      tick();
    end
    stop = 0;
    if (kind == 0) begin
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      m_turns = 0;
    end else begin
      m_turns++;
    end
`ifdef ROBOT_SEQ_LOOP_DETECT_EN
    if (kind == 1 && m_turns == 4) begin
      m_loop = 1;
      outcome = 2;
    end
`endif
    if (outcome == 0 && stop_at >= SC) outcome = 1;
    if (outcome != 0) check_quiet("after_step");
  endtask

  initial begin
    int x, kind, sa, ra, pp;
    bit idle_st;
    reset = 1; start = 1; stop = 0;
    front_sensor = 0; left_sensor = 0;
    nav_front = 0; nav_turn = 0;
    model_reset();
    tick(); check_quiet("rst0");
    tick(); check_quiet("rst1");
    reset = 0; start = 0;
    idle(2);

    do_start();
    run_step(0, -1, -1, o);
    run_step(0, -1, -1, o);
    run_step(0, SC + 4, -1, o);
    chk("stop_in_move", o, 1);
    chk("three_steps", step_count, 3);
    idle(4);

    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    idle(2);

    do_start();
    run_step(0, 0, -1, o);
    chk("settle_stop0", o, 1);
    idle(2);
    do_start();
    run_step(1, SC - 1, -1, o);
    chk("settle_stop1", o, 1);
    idle(2);

    do_start();
    for (int k = 0; k < 4; k++) begin
      run_step(1, -1, -1, o);
      if (o != 0) break;
    end
`ifdef ROBOT_SEQ_LOOP_DETECT_EN
    chk("loop_halt", o, 2);
    halt_hold(3);
    do_reset();
`else
    chk("no_loop", o, 0);
    run_step(0, SC + 2, -1, o);
    chk("after_turns", o, 1);
    idle(2);
`endif

    do_start();
    run_step(2, -1, -1, o);
    chk("illegal_halt", o, 2);
    halt_hold(3);
    do_reset();

    do_start();
    for (int k = 0; k < 8; k++) run_step(0, -1, -1, o);
    run_step(0, SC + 3, -1, o);
    chk("saturate", step_count, CMAX);
    idle(2);

    do_start();
    run_step(1, -1, 5, o);
    chk("reset_turn_cnt", step_count, 0);
    idle(2);

    idle_st = 1;
    for (int r = 0; r < 40; r++) begin
      if (idle_st) begin
        if ($urandom_range(0, 3) == 0) begin
          start = 1; stop = 1;
          tick();
          start = 0; stop = 0;
          check_quiet("rand_start_stop");
        end
        do_start();
      end
      x = $urandom_range(0, 99);
      kind = (x < 60) ? 0 : (x < 97) ? 1 : 2;
      pp = SC + 2 + ((kind == 1) ? TC : MC);
      sa = ($urandom_range(0, 9) == 0) ? $urandom_range(0, pp - 1) : -1;
      ra = ($urandom_range(0, 29) == 0) ? $urandom_range(0, pp - 1) : -1;
      run_step(kind, sa, ra, o);
      idle_st = (o != 0);
      if (o == 2) begin
        halt_hold(2);
        do_reset();
      end else if (o == 1) begin
        idle(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/robot_motion_sequencer.md
# robot_motion_sequencer

Step sequencer for the maze-following robot. It paces the left-wall navigation FSM: it lets the sensors settle, latches them, gives the navigation FSM a one-cycle advance enable, then executes the decided move or turn for a fixed number of cycles. It sits between the raw sensors and motor drivers on one side and the navigation FSM on the other. It also keeps a step count and detects spinning in place.

## Interface
- MOVE_CYCLES, 8: cycles motor_fwd is held per forward step (≥1)
- TURN_CYCLES, 12: cycles motor_turn is held per turn (≥1)
- SETTLE_CYCLES, 2: sensor settle wait before each sample (≥1)
- STEP_W, 16: width of step_count

Ports:
- clk  in  1  clock. One clock for the whole block.
- reset  in  1  reset. Synchronous and active-high.
- start  in  1  level/pulse; begins stepping from IDLE
- stop  in  1  request to return to IDLE
- front_sensor, left_sensor  in  1 each  raw wall sensors
- nav_front, nav_turn  in  1 each  Moore outputs of the navigation FSM
- nav_step  out  1  clock enable for the navigation FSM state register
- sens_front, sens_left  out  1 each  latched sensors fed to the navigation FSM
- motor_fwd, motor_turn  out  1 each  motor commands; never both high
- busy  out  1  high in every state except IDLE and HALT
- step_done  out  1  one-cycle pulse at the end of each completed move or turn
- step_count  out  STEP_W  completed forward steps; saturating
- fault  out  1  sticky; set when the navigation FSM gives an illegal decision
- loop_flag  out  1  sticky; spin detected (see Configuration)

## Operation
- States: IDLE, SETTLE, SAMPLE, DECIDE, MOVE, TURN, HALT.
- Reset (any state, any cycle) → IDLE. All outputs are 0. Timer, counters, stop latch and flags are cleared.
- IDLE: if start=1 and stop=0 → SETTLE and load the timer with SETTLE_CYCLES. If start and stop are both 1, stop wins and the block stays in IDLE.
- SETTLE: counts down for SETTLE_CYCLES cycles. On the exit edge, sens_front/sens_left are loaded from the raw sensors, then → SAMPLE. If stop=1 in SETTLE → IDLE on the next edge and the sensors are not latched.
- SAMPLE: nav_step=1 for exactly this one cycle, then → DECIDE.
- DECIDE:
  - nav_front=1, nav_turn=0 → MOVE, timer loaded with MOVE_CYCLES.
  - nav_turn=1, nav_front=0 → TURN, timer loaded with TURN_CYCLES.
  - both 1 or both 0 → HALT and fault=1.
- MOVE: motor_fwd=1 for every MOVE cycle. On the last cycle: step_done=1, step_count increments (holds at 2^STEP_W−1), and the consecutive-turn counter clears.
- TURN: motor_turn=1 for every TURN cycle. On the last cycle: step_done=1 and the turn counter increments. step_count is unchanged.
- After MOVE/TURN:
  - loop condition met → HALT.
  - otherwise, stop latched → IDLE.
  - otherwise → SETTLE.
- stop asserted in SAMPLE, DECIDE, MOVE or TURN is latched. It does not abort the motion in progress and is cleared on entry to IDLE.
- HALT: all motor outputs and nav_step are 0. The state is left only by reset. fault and loop_flag stay high.
- step_count holds its value across IDLE. It is cleared only by reset.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from input to output.
- start sampled at edge k → SETTLE during cycles k+1..k+SETTLE_CYCLES → SAMPLE (nav_step=1) at cycle k+SETTLE_CYCLES+1 → DECIDE → first motor cycle at k+SETTLE_CYCLES+3.
- The navigation FSM state updates on the edge that ends SAMPLE. nav_front/nav_turn are read in DECIDE.
- Step period: a forward step takes SETTLE_CYCLES+2+MOVE_CYCLES cycles; a turn takes SETTLE_CYCLES+2+TURN_CYCLES.
- motor_fwd is 0 for at least SETTLE_CYCLES+2 cycles between consecutive motions.
- Raw sensor changes outside the latch edge have no effect.

## Configuration
- ROBOT_SEQ_LOOP_DETECT_EN defined:
  - A 3-bit consecutive-turn counter is implemented. The 4th consecutive TURN completion sets loop_flag=1 and enters HALT; step_done still pulses for that turn.
  - Any MOVE completion resets the counter.
- Not defined: no counter exists, loop_flag is tied 0, and turns never cause HALT.

## Test plan
- Reset with start=1 → IDLE with all outputs 0. After reset is released and start is seen: nav_step high exactly 3 cycles later (defaults); sens_* equal the sensor values at the latch edge.
- Navigation model returns front (sensors 00) for 3 steps → motor_fwd high 8 cycles per step with 4-cycle gaps; step_done pulses 3 times; step_count=3; motor_turn never high.
- Navigation model returns turn → motor_turn high exactly 12 cycles; step_count unchanged. With the macro defined, the 4th consecutive turn gives loop_flag=1, HALT, and busy=0. Without the macro, stepping continues.
- stop pulsed in cycle 3 of MOVE → the MOVE completes all 8 cycles, then IDLE with no further nav_step. stop pulsed during SETTLE → IDLE next cycle with no nav_step.
- nav_front=nav_turn=1 in DECIDE → HALT and fault=1, no motor pulse; a later start is ignored until reset.
- Preload near saturation with STEP_W=2 → after 5 moves step_count=3. reset mid-TURN → next cycle all outputs 0 and state IDLE.
